// File: rtl/comm_pkg.sv
// Shared definitions for the matrix-converter leg commutator: state encoding,
// gate index helpers and default dwell times.
package comm_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_STEADY = 3'd1,
    ST_STEP1  = 3'd2,
    ST_STEP2  = 3'd3,
    ST_STEP3  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_FAULT  = 3'd6
  } comm_state_e;

  localparam int T_OFF_DEF = 10;
  localparam int T_ON_DEF  = 2;

  // Forward device of phase p sits on the even gate bit, reverse on the odd one.
  function automatic int fwd_idx(input int p);
    return 2 * p;
  endfunction

  function automatic int rev_idx(input int p);
    return 2 * p + 1;
  endfunction

endpackage

// File: rtl/comm_dwell_timer.sv
// Down-counting dwell timer: load with a dwell of D cycles, done is high on
// the last of those D cycles and stays high until the next load.
module comm_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Dwell counter; saturates at zero once the dwell has elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val - W'(1);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);

endmodule

// File: rtl/mc_commutator.sv
// Four-step current-sign-based commutation controller for one output leg of
// an N-phase matrix converter, with null target, fault latch and status.
module mc_commutator
  import comm_pkg::*;
#(
  parameter int N_PH      = 3,
  parameter int T_OFF_CYC = T_OFF_DEF,
  parameter int T_ON_CYC  = T_ON_DEF,
  parameter int SEL_W     = $clog2(N_PH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  sel,
  input  logic              cur_sign,
  input  logic              fault,
  output logic [2*N_PH-1:0] gate,
  output logic [SEL_W-1:0]  active,
  output logic              busy,
  output logic              fault_st,
  output logic              sel_err
);

  localparam int G_W   = 2 * N_PH;
  localparam int T_MAX = (T_OFF_CYC > T_ON_CYC) ? T_OFF_CYC : T_ON_CYC;
  localparam int DW    = $clog2(T_MAX + 1);

  comm_state_e      state_r, state_nx_s;
  logic [SEL_W-1:0] src_r, src_nx_s;
  logic [SEL_W-1:0] dst_r, dst_nx_s;
  logic             sgn_r, sgn_nx_s;
  logic             err_s;
  logic             sel_ok_s;
  logic [G_W-1:0]   gate_s;
  logic [SEL_W-1:0] active_s;
  logic             busy_s;
  logic             tmr_load_s;
  logic [DW-1:0]    tmr_val_s;
  logic             tmr_done_s;

  assign sel_ok_s   = (int'(sel) <= N_PH);
  assign tmr_load_s = (state_nx_s != state_r);

  comm_dwell_timer #(
    .W(DW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Next state; sel and cur_sign are only looked at once OFF/STEADY dwell has elapsed.
  always_comb begin
    state_nx_s = state_r;
    src_nx_s   = src_r;
    dst_nx_s   = dst_r;
    sgn_nx_s   = sgn_r;
    err_s      = 1'b0;
    if (fault) begin
      state_nx_s = ST_FAULT;
      src_nx_s   = '0;
      dst_nx_s   = '0;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (!tmr_done_s) begin
            state_nx_s = ST_OFF;
          end else if (!sel_ok_s) begin
            err_s = 1'b1;
          end else if (sel != '0) begin
            state_nx_s = ST_STEADY;
            src_nx_s   = sel;
            sgn_nx_s   = cur_sign;
          end else begin
            state_nx_s = ST_OFF;
          end
        end
        ST_STEADY: begin
          if (!tmr_done_s) begin
            state_nx_s = ST_STEADY;
          end else if (!sel_ok_s) begin
            err_s = 1'b1;
          end else if (sel != src_r) begin
            // A zero target takes the drain path after STEP1.
            state_nx_s = ST_STEP1;
            dst_nx_s   = sel;
            sgn_nx_s   = cur_sign;
          end else begin
            state_nx_s = ST_STEADY;
          end
        end
        ST_STEP1: begin
          if (!tmr_done_s) begin
            state_nx_s = ST_STEP1;
          end else if (dst_r == '0) begin
            state_nx_s = ST_DRAIN;
          end else begin
            state_nx_s = ST_STEP2;
          end
        end
        ST_STEP2: begin
          if (tmr_done_s) begin
            state_nx_s = ST_STEP3;
          end else begin
            state_nx_s = ST_STEP2;
          end
        end
        ST_STEP3: begin
          if (tmr_done_s) begin
            state_nx_s = ST_STEADY;
            src_nx_s   = dst_r;
          end else begin
            state_nx_s = ST_STEP3;
          end
        end
        ST_DRAIN: begin
          if (tmr_done_s) begin
            state_nx_s = ST_OFF;
            src_nx_s   = '0;
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end
        ST_FAULT: begin
          if (sel == '0) begin
            state_nx_s = ST_OFF;
          end else begin
            state_nx_s = ST_FAULT;
          end
        end
        default: begin
          state_nx_s = ST_OFF;
          src_nx_s   = '0;
          dst_nx_s   = '0;
        end
      endcase
    end
  end

  // Dwell to load on entry to the next state.
  always_comb begin
    tmr_val_s = DW'(T_OFF_CYC);
    case (state_nx_s)
      ST_STEADY, ST_STEP2: tmr_val_s = DW'(T_ON_CYC);
      default:             tmr_val_s = DW'(T_OFF_CYC);
    endcase
  end

  // Gate pattern and status of the next state, so outputs flip on the state edge.
  always_comb begin
    gate_s = '0;
    for (int p = 0; p < N_PH; p++) begin
      if ((state_nx_s == ST_STEADY) && (src_nx_s == SEL_W'(p + 1))) begin
        gate_s = gate_s | (G_W'(1) << fwd_idx(p)) | (G_W'(1) << rev_idx(p));
      end else if ((((state_nx_s == ST_STEP1) || (state_nx_s == ST_STEP2)) &&
                    (src_nx_s == SEL_W'(p + 1))) ||
                   (((state_nx_s == ST_STEP2) || (state_nx_s == ST_STEP3)) &&
                    (dst_nx_s == SEL_W'(p + 1)))) begin
        gate_s = gate_s | (G_W'(1) << (sgn_nx_s ? fwd_idx(p) : rev_idx(p)));
      end else begin
        gate_s = gate_s;
      end
    end
    if (state_nx_s == ST_STEADY) begin
      active_s = src_nx_s;
    end else begin
      active_s = '0;
    end
    case (state_nx_s)
      ST_STEP1, ST_STEP2, ST_STEP3, ST_DRAIN: busy_s = 1'b1;
      default:                                busy_s = 1'b0;
    endcase
  end

  // State, latched targets and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_OFF;
      src_r    <= '0;
      dst_r    <= '0;
      sgn_r    <= 1'b0;
      gate     <= '0;
      active   <= '0;
      busy     <= 1'b0;
      fault_st <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      src_r    <= src_nx_s;
      dst_r    <= dst_nx_s;
      sgn_r    <= sgn_nx_s;
      gate     <= gate_s;
      active   <= active_s;
      busy     <= busy_s;
      fault_st <= (state_nx_s == ST_FAULT);
      sel_err  <= err_s;
    end
  end

endmodule

// File: tb/tb_mc_commutator.sv
// Directed bench for mc_commutator: a default 3-phase leg plus a fast 4-phase
// leg used for the invalid-select pulse and a randomised safety sweep.
module tb_mc_commutator;

  localparam int T_OFF = 10;
  localparam int T_ON  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       cur_sign;
  logic       fault;
  logic [5:0] gate;
  logic [1:0] active;
  logic       busy, fault_st, sel_err;

  logic [2:0] sel4;
  logic       sign4;
  logic       fault4;
  logic [7:0] gate4;
  logic [2:0] active4;
  logic       busy4, fault_st4, sel_err4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_commutator u_dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .cur_sign (cur_sign),
    .fault    (fault),
    .gate     (gate),
    .active   (active),
    .busy     (busy),
    .fault_st (fault_st),
    .sel_err  (sel_err)
  );

  mc_commutator #(
    .N_PH      (4),
    .T_OFF_CYC (3),
    .T_ON_CYC  (1)
  ) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel4),
    .cur_sign (sign4),
    .fault    (fault4),
    .gate     (gate4),
    .active   (active4),
    .busy     (busy4),
    .fault_st (fault_st4),
    .sel_err  (sel_err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Current pattern must be seen on d consecutive cycles starting now.
  task automatic hold(input string tag, input logic [5:0] exp, input int d);
    check(tag, 32'(gate), 32'(exp));
    for (int i = 1; i < d; i++) begin
      step();
      check(tag, 32'(gate), 32'(exp));
    end
  endtask

  // Starts right after STEADY entry; cur_sign is toggled mid-way and must be ignored.
  task automatic commute(input string tag, input logic [1:0] nsel, input logic sgn,
                         input logic [5:0] p1, input logic [5:0] p2,
                         input logic [5:0] p3, input logic [5:0] pf);
    step();
    step();
    sel      = nsel;
    cur_sign = sgn;
    step();
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    check({tag, ".act0"}, 32'(active), 32'd0);
    cur_sign = ~sgn;
    hold({tag, ".s1"}, p1, T_OFF);
    step();
    cur_sign = sgn;
    hold({tag, ".s2"}, p2, T_ON);
    step();
    cur_sign = ~sgn;
    hold({tag, ".s3"}, p3, T_OFF);
    step();
    check({tag, ".fin"}, 32'(gate), 32'(pf));
    check({tag, ".act"}, 32'(active), 32'(nsel));
    check({tag, ".busy0"}, 32'(busy), 32'd0);
  endtask

  function automatic logic safe4(input logic [7:0] g);
    logic [7:0] tp, tq;
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b1;
    for (int p = 0; p < 4; p++) begin
      tp = g >> (2 * p);
      if (tp[0] || tp[1]) n++;
      for (int q = 0; q < 4; q++) begin
        tq = g >> (2 * q);
        if ((p != q) && tp[0] && tq[1]) ok = 1'b0;
      end
    end
    return ok && (n <= 2);
  endfunction

  initial begin
    rst = 1'b1; sel = 2'd0; cur_sign = 1'b0; fault = 1'b0;
    sel4 = 3'd0; sign4 = 1'b0; fault4 = 1'b0;
    step();
    step();
    check("rst.gate", 32'(gate), 32'd0);
    check("rst.active", 32'(active), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.fault_st", 32'(fault_st), 32'd0);
    check("rst.sel_err", 32'(sel_err), 32'd0);
    check("rst.gate4", 32'(gate4), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // OFF -> STEADY on phase 0
    sel = 2'd1; cur_sign = 1'b1;
    step();
    check("on.gate", 32'(gate), 32'h03);
    check("on.active", 32'(active), 32'd1);
    check("on.busy", 32'(busy), 32'd0);

    commute("c01p", 2'd2, 1'b1, 6'b000001, 6'b000101, 6'b000100, 6'b001100);
    commute("c10n", 2'd1, 1'b0, 6'b001000, 6'b001010, 6'b000010, 6'b000011);
    commute("c01n", 2'd2, 1'b0, 6'b000010, 6'b001010, 6'b001000, 6'b001100);
    commute("c12p", 2'd3, 1'b1, 6'b000100, 6'b010100, 6'b010000, 6'b110000);

    // Null transition from phase 2
    step();
    step();
    sel = 2'd0; cur_sign = 1'b1;
    step();
    hold("null.s1", 6'b010000, T_OFF);
    step();
    hold("null.drain", 6'b000000, T_OFF);
    check("null.busy_last", 32'(busy), 32'd1);
    step();
    check("null.busy_off", 32'(busy), 32'd0);
    check("null.active", 32'(active), 32'd0);

    // OFF minimum dwell before sel=1 is honoured
    sel = 2'd1; cur_sign = 1'b1;
    hold("offdwell", 6'b000000, T_OFF);
    step();
    check("offdwell.on", 32'(gate), 32'h03);

    // Fault during STEP2
    step();
    step();
    sel = 2'd2;
    step();
    hold("flt.s1", 6'b000001, T_OFF);
    step();
    check("flt.s2", 32'(gate), 32'h05);
    fault = 1'b1;
    step();
    check("flt.gate", 32'(gate), 32'd0);
    check("flt.fault_st", 32'(fault_st), 32'd1);
    check("flt.busy", 32'(busy), 32'd0);
    check("flt.active", 32'(active), 32'd0);
    fault = 1'b0; sel = 2'd1;
    step();
    step();
    step();
    check("flt.hold", 32'(fault_st), 32'd1);
    check("flt.hold_gate", 32'(gate), 32'd0);
    sel = 2'd0;
    step();
    check("flt.exit", 32'(fault_st), 32'd0);
    check("flt.exit_gate", 32'(gate), 32'd0);

    // Asynchronous reset in the middle of a commutation
    sel = 2'd1;
    for (int i = 0; i < T_OFF; i++) step();
    check("ar.on", 32'(gate), 32'h03);
    step();
    step();
    sel = 2'd2;
    step();
    check("ar.s1", 32'(gate), 32'h01);
    #2;
    rst = 1'b1;
    #1;
    check("ar.gate", 32'(gate), 32'd0);
    check("ar.busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    sel = 2'd0;

    // Invalid select on the 4-phase leg
    sel4 = 3'd1; sign4 = 1'b1;
    step();
    check("n4.on", 32'(gate4), 32'h03);
    check("n4.active", 32'(active4), 32'd1);
    sel4 = 3'd5;
    step();
    check("n4.err", 32'(sel_err4), 32'd1);
    check("n4.err_gate", 32'(gate4), 32'h03);
    check("n4.err_active", 32'(active4), 32'd1);
    check("n4.err_busy", 32'(busy4), 32'd0);
    sel4 = 3'd1;
    step();
    check("n4.err_pulse", 32'(sel_err4), 32'd0);

    // Random sweep on the 4-phase leg
    for (int i = 0; i < 3000; i++) begin
      sel4   = 3'($urandom_range(0, 7));
      sign4  = 1'($urandom_range(0, 1));
      fault4 = ($urandom_range(0, 63) == 0);
      step();
      check("n4.safe", 32'(safe4(gate4)), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
